// File: rtl/stream_mux.sv
// N-input packet-aware stream multiplexer with fixed-select or round-robin
// arbitration, per-packet locking and a registered output stage.
module stream_mux #(
  parameter int WIDTH     = 8,
  parameter int NUM_IN    = 8,
  parameter int SEL_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic [SEL_WIDTH-1:0]    select,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN-1:0]       in_last,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    out_last,
  output logic [SEL_WIDTH-1:0]    out_chan,
  input  logic                    out_ready
);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e               state_q, state_d;
  logic [SEL_WIDTH-1:0] lock_q, lock_d;
  logic [SEL_WIDTH-1:0] rr_q, rr_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic [SEL_WIDTH-1:0] chan_q, chan_d;

  logic                 can_load;
  logic                 cand_vld;
  logic [SEL_WIDTH-1:0] cand;
  logic                 hi_hit, lo_hit;
  logic [SEL_WIDTH-1:0] hi_idx, lo_idx;
  logic [WIDTH-1:0]     g_data;
  logic                 g_last;
  logic                 xfer;

  assign can_load = !valid_q || out_ready;

  // Descending scan so the lowest index above / at-or-below rr_q wins.
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        if (SEL_WIDTH'(i) > rr_q) begin
          hi_hit = 1'b1;
          hi_idx = SEL_WIDTH'(i);
        end else begin
          lo_hit = 1'b1;
          lo_idx = SEL_WIDTH'(i);
        end
      end
    end
  end

  always_comb begin
    cand     = '0;
    cand_vld = 1'b0;
    if (state_q == LOCKED) begin
      cand     = lock_q;
      cand_vld = 1'b1;
    end else if (mode) begin
      cand     = hi_hit ? hi_idx : lo_idx;
      cand_vld = hi_hit || lo_hit;
    end else begin
      cand     = select;
      cand_vld = int'(select) < NUM_IN;
    end
  end

  always_comb begin
    in_ready = '0;
    g_data   = '0;
    g_last   = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (cand == SEL_WIDTH'(i)) begin
        g_data      = in_data[i*WIDTH +: WIDTH];
        g_last      = in_last[i];
        in_ready[i] = cand_vld && can_load &&
                      !reset && in_valid[i];
      end
    end
  end

  assign xfer = |(in_valid & in_ready);

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    rr_d    = rr_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    chan_d  = chan_q;
    if (xfer) begin
      data_d  = g_data;
      last_d  = g_last;
      chan_d  = cand;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          rr_d = cand;
          if (!g_last) begin
            state_d = LOCKED;
            lock_d  = cand;
          end
        end
      end
      LOCKED: begin
        if (xfer && g_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lock_q  <= '0;
      rr_q    <= SEL_WIDTH'(NUM_IN - 1);
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      rr_q    <= rr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      chan_q  <= chan_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign out_chan  = chan_q;

endmodule

// File: tb/tb_stream_mux.sv
// Directed self-checking bench for stream_mux (8 channels, 8-bit data).
module tb_stream_mux;

  logic        clk;
  logic        reset;
  logic        mode;
  logic [2:0]  select;
  logic [63:0] in_data;
  logic [7:0]  in_valid;
  logic [7:0]  in_last;
  logic [7:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic [2:0]  out_chan;
  logic        out_ready;

  int total;
  int passed;

  stream_mux #(.WIDTH(8), .NUM_IN(8), .SEL_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .mode(mode), .select(select),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .out_chan(out_chan), .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [7:0] d,
                        input logic v, input logic l);
    in_data[c*8 +: 8] = d;
    in_valid[c] = v;
    in_last[c]  = l;
  endtask

  task automatic all_single();
    for (int i = 0; i < 8; i++) set_ch(i, 8'hA0 + 8'(i), 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = '0;
    in_last = '0;
    in_data = '0;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mode = 1'b1;
    select = 3'd0;
    out_ready = 1'b1;
    all_single();
    #1;
    total++; if (in_ready !== 8'h00) $display("FAIL rst_ready: got %h want 00", in_ready); else passed++;
    tick();
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else passed++;
    total++; if (out_data !== 8'h00) $display("FAIL rst_data: got %h want 00", out_data); else passed++;
    total++; if (out_last !== 1'b0) $display("FAIL rst_last: got %b want 0", out_last); else passed++;
    total++; if (out_chan !== 3'd0) $display("FAIL rst_chan: got %0d want 0", out_chan); else passed++;
    reset = 1'b0;
    in_valid = '0;
  endtask

  task automatic test_fixed_select();
    do_reset();
    mode = 1'b0;
    select = 3'd5;
    all_single();
    #1;
    total++; if (in_ready !== 8'h20) $display("FAIL sel_ready: got %h want 20", in_ready); else passed++;
    tick();
    total++; if (out_valid !== 1'b1) $display("FAIL sel_valid: got %b want 1", out_valid); else passed++;
    total++; if (out_data !== 8'hA5) $display("FAIL sel_data: got %h want a5", out_data); else passed++;
    total++; if (out_chan !== 3'd5) $display("FAIL sel_chan: got %0d want 5", out_chan); else passed++;
    total++; if (out_last !== 1'b1) $display("FAIL sel_last: got %b want 1", out_last); else passed++;
    in_valid = '0;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL sel_drain: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_rdy;
    do_reset();
    mode = 1'b1;
    all_single();
    for (int k = 0; k < 9; k++) begin
      exp_rdy = 8'h01 << (k % 8);
      #1;
      total++; if (in_ready !== exp_rdy) $display("FAIL rr_ready k%0d: got %h want %h", k, in_ready, exp_rdy); else passed++;
      tick();
      total++; if (out_chan !== 3'(k % 8) || out_valid !== 1'b1) $display("FAIL rr_chan k%0d: got %0d/%b want %0d/1", k, out_chan, out_valid, k % 8); else passed++;
      total++; if (out_data !== 8'hA0 + 8'(k % 8)) $display("FAIL rr_data k%0d: got %h want %h", k, out_data, 8'hA0 + 8'(k % 8)); else passed++;
    end
    in_valid = '0;
  endtask

  task automatic test_packet_lock();
    do_reset();
    mode = 1'b1;
    set_ch(3, 8'hA3, 1'b1, 1'b1);
    set_ch(6, 8'hA6, 1'b1, 1'b1);
    for (int b = 0; b < 4; b++) begin
      set_ch(2, 8'h20 + 8'(b), 1'b1, b == 3);
      #1;
      total++; if (in_ready !== 8'h04) $display("FAIL lock_ready b%0d: got %h want 04", b, in_ready); else passed++;
      tick();
      total++; if (out_chan !== 3'd2 || out_data !== 8'h20 + 8'(b)) $display("FAIL lock_beat b%0d: got ch%0d %h want ch2 %h", b, out_chan, out_data, 8'h20 + 8'(b)); else passed++;
      total++; if (out_last !== (b == 3)) $display("FAIL lock_last b%0d: got %b want %b", b, out_last, b == 3); else passed++;
    end
    set_ch(2, 8'h00, 1'b0, 1'b0);
    tick();
    total++; if (out_chan !== 3'd3 || out_data !== 8'hA3) $display("FAIL lock_next: got ch%0d %h want ch3 a3", out_chan, out_data); else passed++;
    set_ch(3, 8'h00, 1'b0, 1'b0);
    tick();
    total++; if (out_chan !== 3'd6 || out_data !== 8'hA6) $display("FAIL lock_next2: got ch%0d %h want ch6 a6", out_chan, out_data); else passed++;
    in_valid = '0;
  endtask

  task automatic test_valid_gap();
    do_reset();
    mode = 1'b0;
    select = 3'd5;
    set_ch(5, 8'h50, 1'b1, 1'b0);
    tick();
    total++; if (out_chan !== 3'd5 || out_last !== 1'b0) $display("FAIL gap_first: got ch%0d last%b want ch5 last0", out_chan, out_last); else passed++;
    set_ch(5, 8'h00, 1'b0, 1'b0);
    set_ch(1, 8'hA1, 1'b1, 1'b1);
    select = 3'd1;
    #1;
    total++; if (in_ready !== 8'h00) $display("FAIL gap_ready: got %h want 00", in_ready); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL gap_valid: got %b want 0", out_valid); else passed++;
    set_ch(5, 8'h51, 1'b1, 1'b1);
    #1;
    total++; if (in_ready !== 8'h20) $display("FAIL gap_resume: got %h want 20", in_ready); else passed++;
    tick();
    total++; if (out_data !== 8'h51 || out_last !== 1'b1) $display("FAIL gap_end: got %h last%b want 51 last1", out_data, out_last); else passed++;
    set_ch(5, 8'h00, 1'b0, 1'b0);
    #1;
    total++; if (in_ready !== 8'h02) $display("FAIL gap_after: got %h want 02", in_ready); else passed++;
    in_valid = '0;
  endtask

  task automatic test_select_change();
    do_reset();
    mode = 1'b0;
    select = 3'd1;
    set_ch(4, 8'hA4, 1'b1, 1'b1);
    for (int b = 0; b < 3; b++) begin
      if (b == 1) select = 3'd4;
      set_ch(1, 8'h10 + 8'(b), 1'b1, b == 2);
      #1;
      total++; if (in_ready !== 8'h02) $display("FAIL sc_ready b%0d: got %h want 02", b, in_ready); else passed++;
      tick();
      total++; if (out_chan !== 3'd1 || out_data !== 8'h10 + 8'(b) || out_last !== (b == 2)) $display("FAIL sc_beat b%0d: got ch%0d %h last%b", b, out_chan, out_data, out_last); else passed++;
    end
    set_ch(1, 8'h00, 1'b0, 1'b0);
    tick();
    total++; if (out_chan !== 3'd4 || out_data !== 8'hA4) $display("FAIL sc_next: got ch%0d %h want ch4 a4", out_chan, out_data); else passed++;
    in_valid = '0;
  endtask

  task automatic test_back_pressure();
    do_reset();
    mode = 1'b0;
    select = 3'd0;
    out_ready = 1'b1;
    set_ch(0, 8'h50, 1'b1, 1'b0);
    tick();
    total++; if (out_data !== 8'h50 || out_valid !== 1'b1) $display("FAIL bp_a: got %h/%b want 50/1", out_data, out_valid); else passed++;
    set_ch(0, 8'h51, 1'b1, 1'b0);
    for (int c = 0; c < 2; c++) begin
      out_ready = 1'b0;
      #1;
      total++; if (in_ready !== 8'h00) $display("FAIL bp_ready c%0d: got %h want 00", c, in_ready); else passed++;
      tick();
      total++; if (out_data !== 8'h50 || out_valid !== 1'b1 || out_last !== 1'b0) $display("FAIL bp_hold c%0d: got %h/%b/%b want 50/1/0", c, out_data, out_valid, out_last); else passed++;
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 8'h01) $display("FAIL bp_release: got %h want 01", in_ready); else passed++;
    tick();
    total++; if (out_data !== 8'h51 || out_valid !== 1'b1) $display("FAIL bp_d: got %h/%b want 51/1", out_data, out_valid); else passed++;
    set_ch(0, 8'h52, 1'b1, 1'b1);
    tick();
    total++; if (out_data !== 8'h52 || out_last !== 1'b1) $display("FAIL bp_e: got %h last%b want 52 last1", out_data, out_last); else passed++;
    set_ch(0, 8'h00, 1'b0, 1'b0);
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL bp_drain: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    mode = 1'b1;
    set_ch(3, 8'h30, 1'b1, 1'b0);
    tick();
    total++; if (out_chan !== 3'd3 || out_data !== 8'h30) $display("FAIL rmp_first: got ch%0d %h want ch3 30", out_chan, out_data); else passed++;
    set_ch(3, 8'h31, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    total++; if (in_ready !== 8'h00) $display("FAIL rmp_ready: got %h want 00", in_ready); else passed++;
    tick();
    total++; if (out_valid !== 1'b0 || out_chan !== 3'd0) $display("FAIL rmp_out: got %b ch%0d want 0 ch0", out_valid, out_chan); else passed++;
    reset = 1'b0;
    set_ch(0, 8'hA0, 1'b1, 1'b1);
    #1;
    total++; if (in_ready !== 8'h01) $display("FAIL rmp_regrant: got %h want 01", in_ready); else passed++;
    tick();
    total++; if (out_chan !== 3'd0 || out_data !== 8'hA0) $display("FAIL rmp_chan: got ch%0d %h want ch0 a0", out_chan, out_data); else passed++;
    in_valid = '0;
  endtask

  initial begin
    total = 0;
    passed = 0;
    reset = 1'b1;
    mode = 1'b0;
    select = '0;
    in_data = '0;
    in_valid = '0;
    in_last = '0;
    out_ready = 1'b1;
    test_reset();
    test_fixed_select();
    test_round_robin();
    test_packet_lock();
    test_valid_gap();
    test_select_change();
    test_back_pressure();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
